// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: op codes and sequencer states.
package alu_pkg;

    // ALU select encodings driven on reqN_op
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_MUL = 3'b110;
    localparam logic [2:0] ALU_DIV = 3'b111;

    // Sequencer flow: accept in IDLE, compute in EXEC, hold result in RESP
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latched operation waiting in the sequencer
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
    } alu_req_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational 4-bit ALU producing an 8-bit result.
module alu_core
    import alu_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [2:0] i_op,
    output logic [7:0] o_result
);

    logic [7:0] w_a_ext;
    logic [7:0] w_b_ext;

    assign w_a_ext = {4'h0, i_a};
    assign w_b_ext = {4'h0, i_b};

    // Select the operation result; subtraction wraps mod 256, divide-by-zero yields zero
    always_comb begin
        // NOTE: a default before the case keeps every path assigned, so no latch is inferred.
        o_result = 8'h00;
        case (i_op)
            ALU_ADD: o_result = w_a_ext + w_b_ext;
            ALU_SUB: o_result = w_a_ext - w_b_ext;
            ALU_AND: o_result = w_a_ext & w_b_ext;
            ALU_OR:  o_result = w_a_ext | w_b_ext;
            ALU_XOR: o_result = w_a_ext ^ w_b_ext;
            ALU_NOT: o_result = {~i_b, ~i_a};
            ALU_MUL: o_result = w_a_ext * w_b_ext;
            ALU_DIV: o_result = (i_b == 4'h0) ? 8'h00 : (w_a_ext / w_b_ext);
            default: o_result = 8'h00;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester round-robin arbiter and IDLE/EXEC/RESP sequencer for a shared ALU.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int unsigned CNT_W = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_a,
    input  logic [3:0]       req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_a,
    input  logic [3:0]       req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_data,
    output logic             rsp_id,
    output logic             busy,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_rr_ptr;
    alu_req_t         r_req;
    logic             r_id;
    logic [7:0]       r_rsp_data;
    logic [CNT_W-1:0] r_cnt0;
    logic [CNT_W-1:0] r_cnt1;

    logic             w_grant0;
    logic             w_grant1;
    logic             w_rsp_done;
    logic [7:0]       w_alu_result;

    // Next state and grant decode; grants only in IDLE and never while reset is held
    always_comb begin
        w_state_next = r_state;
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst) begin
                    if (req0_valid && (!req1_valid || !r_rr_ptr)) begin
                        w_grant0     = 1'b1;
                        w_state_next = EXEC;
                    end else if (req1_valid && (!req0_valid || r_rr_ptr)) begin
                        w_grant1     = 1'b1;
                        w_state_next = EXEC;
                    end
                end
            end
            EXEC: w_state_next = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_rsp_done = (r_state == RESP) && rsp_ready;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Round-robin pointer flips to the other requester on every grant
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_grant0) begin
            r_rr_ptr <= 1'b1;
        end else if (w_grant1) begin
            r_rr_ptr <= 1'b0;
        end
    end

    // Capture operands of the granted requester
    always_ff @(posedge clk) begin
        // NOTE: operand latches carry no reset; they are always loaded by a grant before EXEC reads them.
        if (w_grant0) begin
            r_req <= '{a: req0_a, b: req0_b, op: req0_op};
        end else if (w_grant1) begin
            r_req <= '{a: req1_a, b: req1_b, op: req1_op};
        end
    end

    // Requester ID is visible on rsp_id, so it resets to a defined value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id <= 1'b0;
        end else if (w_grant0) begin
            r_id <= 1'b0;
        end else if (w_grant1) begin
            r_id <= 1'b1;
        end
    end

    alu_core u_alu_core (
        .i_a      (r_req.a),
        .i_b      (r_req.b),
        .i_op     (r_req.op),
        .o_result (w_alu_result)
    );

    // Register the ALU result in EXEC; it then holds through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_data <= 8'h00;
        end else if (r_state == EXEC) begin
            r_rsp_data <= w_alu_result;
        end
    end

    // Completion counters advance on the response handshake, wrapping naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else if (w_rsp_done) begin
            if (r_id) begin
                r_cnt1 <= r_cnt1 + CNT_W'(1);
            end else begin
                r_cnt0 <= r_cnt0 + CNT_W'(1);
            end
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp_valid  = (r_state == RESP);
    assign rsp_data   = r_rsp_data;
    assign rsp_id     = r_id;
    assign busy       = (r_state != IDLE);
    assign cnt0       = r_cnt0;
    assign cnt1       = r_cnt1;

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-requester round-robin arbiter and sequencer for the shared 4-bit ALU. It accepts operation requests from two independent masters over valid/ready handshakes and grants the ALU to one at a time. It sequences each granted operation through a fixed IDLE→EXEC→RESP flow and returns an 8-bit result tagged with the requester ID. It also keeps per-requester completion counters for debug readout.

## Interface
Parameters:
- CNT_W, 8, width of per-requester completion counters

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  4 each  requester 0 operands
- req0_op  in  3  requester 0 ALU select
- req1_valid, req1_ready, req1_a, req1_b, req1_op  —  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  8  ALU result
- rsp_id  out  1  requester that issued the operation
- busy  out  1  high in EXEC or RESP
- cnt0, cnt1  out  CNT_W each  completed-operation counts per requester

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no valid requests: stay in IDLE.
- IDLE, exactly one reqN_valid: grant N.
- IDLE, both valid: grant the requester indicated by rr_ptr.
- On grant: assert the granted reqN_ready for that cycle only (combinational from state, valid and rr_ptr). Latch a, b, op and id. Set rr_ptr to the other requester. Go to EXEC.
- EXEC: the ALU computes from the latched operands. Register the result into rsp_data. Go to RESP.
- RESP: hold rsp_valid=1, rsp_data and rsp_id stable until rsp_ready=1. On that handshake cycle, increment cnt[id] (wraps mod 2^CNT_W) and go to IDLE.
- reqN_ready is 0 in EXEC and RESP. A request is never accepted in the same cycle a response completes.
- rr_ptr updates only on a contested or uncontested grant. Initial priority after reset is requester 0.
- ALU op encoding; a and b are unsigned 4-bit, result is 8-bit:
  - 000: a+b, zero-extended.
  - 001: (a−b) mod 256, 8-bit two's complement, so 3−5 = 0xFE.
  - 010 / 011 / 100: a&b, a|b, a^b, zero-extended.
  - 101: {~b,~a}.
  - 110: a*b.
  - 111: a/b truncated and zero-extended; b=0 gives 0x00.
- Reset mid-operation: the in-flight transaction is discarded without a response. Counters are not incremented.

## Timing
- Reset values: state=IDLE, rr_ptr=0, rsp_valid=0, rsp_data=0x00, rsp_id=0, busy=0, cnt0=cnt1=0. req0_ready and req1_ready are 0 during reset.
- Latency: grant in cycle T, rsp_valid high from T+2.
- Minimum issue interval is 3 cycles, with rsp_ready held high.
- rsp_data and rsp_id must not change while rsp_valid=1 and rsp_ready=0.
- Requesters must hold valid and operands stable until ready. Deasserting valid before ready is permitted, and that request is simply not taken.
- busy = (state != IDLE), registered-state decode, no glitch path from inputs.

## Structure
- Shared package alu_pkg holds:
  - 3-bit op codes ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT, ALU_MUL, ALU_DIV.
  - The state typedef (IDLE/EXEC/RESP).
- One sub-module, alu_core: purely combinational a, b, op → 8-bit result, no clock or reset. The arbiter instantiates it once on the latched operands.
- Arbitration, FSM, latches and counters live in the top.

## Test plan
- Single request: req0 a=9 b=3 op=000, rsp_ready=1.
  - Expect: req0_ready in cycle T, rsp_valid at T+2 with rsp_data=0x0C and rsp_id=0, cnt0=1.
- Contention: both valid continuously, req0 op=110 a=15 b=15, req1 op=111 a=13 b=4.
  - Expect: grants alternate 0,1,0,1, responses 0xE1 (id0) and 0x03 (id1).
- Backpressure: rsp_ready=0 for 5 cycles in RESP with op=001 a=3 b=5.
  - Expect: rsp_data=0xFE held stable, no reqN_ready asserted, completion only when rsp_ready rises.
- Edge ops: a=6 b=0 op=111 gives 0x00. a=0x5 b=0xA op=101 gives 0x5A. a=0xC b=0xA op=100 gives 0x06.
- Reset in EXEC: assert rst one cycle.
  - Expect: rsp_valid never rises for that op, cnt unchanged at 0, rr_ptr=0, next contested grant goes to req0.
- Counter wrap (CNT_W=2): five req1 completions.
  - Expect: cnt1 sequence 1,2,3,0,1, cnt0 stays 0.
